// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and helpers for deriving sync windows.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a; the raster runs free at one pixel per clock.
package vga_timing_pkg;

   // Counter width; wide enough for 799 and 524 without truncation.
   localparam int CNT_W = 10;

   // Default 640x480 timing.
   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;   // 800
   localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;   // 525

   localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;                        // 656
   localparam int H_SYNC_END   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC - 1;       // 751
   localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;                        // 490
   localparam int V_SYNC_END   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC - 1;       // 491

   // First counter value inside the sync pulse.
   function automatic int syncStart(input int visible, input int front);
      return visible + front;
   endfunction

   // Last counter value inside the sync pulse (inclusive).
   function automatic int syncEnd(input int visible, input int front, input int sync);
      return visible + front + sync - 1;
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with enable, synchronous reset and a wrap flag.
// Latency: count updates on the clock edge after enable; wrap is combinational from state and enable.
// Backpressure: none; enable low simply holds the count.
// Ports: clock25MHz, reset (sync, active-high), enable, count[9:0], wrap (high on the cycle count goes MODULUS-1 -> 0).
module mod_counter
   import vga_timing_pkg::*;
#(
   parameter int MODULUS = 800
) (
   input  logic             clock25MHz,
   input  logic             reset,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

   assign wrap = enable && (count == LAST);

   always_ff @(posedge clock25MHz) begin
      if (reset) begin
         count <= '0;
      end else if (enable) begin
         count <= wrap ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: x/y counters, active-low syncs, blanked registered RGB and frame counter.
// Latency: x, y, video_on, frame_start are counter state (0 cycles); hsync, vsync, RGB lag x,y by 1 cycle.
// Backpressure: none; free-running at one pixel per clock, the pattern source must answer combinationally.
// Ports: clock25MHz, reset (sync, active-high), red_in/green_in/blue_in[3:0] for the current x,y;
//        x[9:0], y[9:0], video_on, frame_start, hsync, vsync, red/green/blue[3:0], frame_count[7:0].
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK
) (
   input  logic             clock25MHz,
   input  logic             reset,
   input  logic [3:0]       red_in,
   input  logic [3:0]       green_in,
   input  logic [3:0]       blue_in,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             video_on,
   output logic             frame_start,
   output logic             hsync,
   output logic             vsync,
   output logic [3:0]       red,
   output logic [3:0]       green,
   output logic [3:0]       blue,
   output logic [7:0]       frame_count
);

   localparam int LINE_LEN    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CNT_W-1:0] H_VIS_W  = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS_W  = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(syncStart(H_VISIBLE, H_FRONT));
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(syncEnd(H_VISIBLE, H_FRONT, H_SYNC));
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(syncStart(V_VISIBLE, V_FRONT));
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(syncEnd(V_VISIBLE, V_FRONT, V_SYNC));

   logic hWrap;
   logic vWrap;

   mod_counter #(.MODULUS(LINE_LEN)) hCounter (
      .clock25MHz (clock25MHz),
      .reset      (reset),
      .enable     (1'b1),
      .count      (x),
      .wrap       (hWrap)
   );

   // Vertical only advances on the horizontal wrap, so its wrap flag
   // marks the last pixel of the frame.
   mod_counter #(.MODULUS(FRAME_LINES)) vCounter (
      .clock25MHz (clock25MHz),
      .reset      (reset),
      .enable     (hWrap),
      .count      (y),
      .wrap       (vWrap)
   );

   assign video_on    = (x < H_VIS_W) && (y < V_VIS_W);
   assign frame_start = (x == '0) && (y == '0);

   always_ff @(posedge clock25MHz) begin
      if (reset) begin
         // Syncs forced inactive so a mid-frame reset never leaves a partial pulse.
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         frame_count <= '0;
      end else begin
         hsync <= !((x >= HS_START) && (x <= HS_END));
         vsync <= !((y >= VS_START) && (y <= VS_END));
         red   <= video_on ? red_in   : 4'h0;
         green <= video_on ? green_in : 4'h0;
         blue  <= video_on ? blue_in  : 4'h0;
         if (hWrap && vWrap) begin
            frame_count <= frame_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default-timing instance for reset and line checks, a reduced-timing
// instance (15x8 raster) so full frames and the 256-frame wrap fit a short run.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [3:0] rIn, gIn, bIn;

   logic [9:0] bx, by;
   logic       bVideo, bFs, bHs, bVs;
   logic [3:0] bR, bG, bB;
   logic [7:0] bFc;

   logic [9:0] sx, sy;
   logic       sVideo, sFs, sHs, sVs;
   logic [3:0] sR, sG, sB;
   logic [7:0] sFc;

   int checks   = 0;
   int failures = 0;

   vga_sync_gen dutBig (
      .clock25MHz (clk), .reset (reset),
      .red_in (rIn), .green_in (gIn), .blue_in (bIn),
      .x (bx), .y (by), .video_on (bVideo), .frame_start (bFs),
      .hsync (bHs), .vsync (bVs),
      .red (bR), .green (bG), .blue (bB), .frame_count (bFc)
   );

   // Small raster: H 8/2/3/2 -> 15 (hsync x in [10,12]), V 4/1/2/1 -> 8 (vsync y in [5,6]).
   vga_sync_gen #(
      .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
      .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
   ) dutSmall (
      .clock25MHz (clk), .reset (reset),
      .red_in (rIn), .green_in (gIn), .blue_in (bIn),
      .x (sx), .y (sy), .video_on (sVideo), .frame_start (sFs),
      .hsync (sHs), .vsync (sVs),
      .red (sR), .green (sG), .blue (sB), .frame_count (sFc)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; rIn = 4'hF; gIn = 4'hA; bIn = 4'h5;
      repeat (5) step();
      checks++; if (bR !== 4'h0)   begin failures++; $display("FAIL reset_red got=%0h exp=0", bR); end
      checks++; if (bHs !== 1'b1)  begin failures++; $display("FAIL reset_hsync got=%b exp=1", bHs); end
      checks++; if (bVs !== 1'b1)  begin failures++; $display("FAIL reset_vsync got=%b exp=1", bVs); end
      checks++; if (bx !== 10'd0)  begin failures++; $display("FAIL reset_x got=%0d exp=0", bx); end
      checks++; if (by !== 10'd0)  begin failures++; $display("FAIL reset_y got=%0d exp=0", by); end
      checks++; if (bFc !== 8'd0)  begin failures++; $display("FAIL reset_frame_count got=%0d exp=0", bFc); end
      checks++; if (bFs !== 1'b1)  begin failures++; $display("FAIL reset_frame_start got=%b exp=1", bFs); end
      checks++; if (bVideo !== 1'b1) begin failures++; $display("FAIL reset_video_on got=%b exp=1", bVideo); end
      reset = 1'b0;
      step();
      checks++; if (bx !== 10'd1)  begin failures++; $display("FAIL release_x got=%0d exp=1", bx); end
      checks++; if (by !== 10'd0)  begin failures++; $display("FAIL release_y got=%0d exp=0", by); end
   endtask

   // Default instance, starting at x=1: two lines of hsync and colour timing.
   task automatic test_line_timing();
      int prevX = bx, prevY = by;
      logic prevHs = bHs;
      int fall1 = -1, fall2 = -1, fallX = -1, lowCnt = 0, width = -1;
      int yBefore = -1, yAfter = -1;
      logic [3:0] red639 = 4'h0, green639 = 4'h0, red640 = 4'hF;
      for (int c = 1; c <= 1700; c++) begin
         step();
         if (prevHs && !bHs) begin
            if (fall1 < 0) begin fall1 = c; fallX = prevX; end
            else if (fall2 < 0) fall2 = c;
         end
         if (!bHs) lowCnt++;
         else if (!prevHs && width < 0) width = lowCnt;
         if (prevX == 799 && bx == 10'd0 && yBefore < 0) begin yBefore = prevY; yAfter = int'(by); end
         if (prevX == 639 && prevY == 0) begin red639 = bR; green639 = bG; end
         if (prevX == 640 && prevY == 0) red640 = bR;
         prevX = int'(bx); prevY = int'(by); prevHs = bHs;
      end
      checks++; if (fallX != 656) begin failures++; $display("FAIL hsync_fall_x got=%0d exp=656", fallX); end
      checks++; if (width != 96)  begin failures++; $display("FAIL hsync_width got=%0d exp=96", width); end
      checks++; if (fall2 - fall1 != 800) begin failures++; $display("FAIL hsync_period got=%0d exp=800", fall2 - fall1); end
      checks++; if (yBefore != 0 || yAfter != 1) begin failures++; $display("FAIL y_step got=%0d->%0d exp=0->1", yBefore, yAfter); end
      checks++; if (red639 !== 4'hF)   begin failures++; $display("FAIL red_x639 got=%0h exp=f", red639); end
      checks++; if (green639 !== 4'hA) begin failures++; $display("FAIL green_x639 got=%0h exp=a", green639); end
      checks++; if (red640 !== 4'h0)   begin failures++; $display("FAIL red_x640 got=%0h exp=0", red640); end
   endtask

   // Small instance: vsync window, frame period, frame_count step and blanking over two frames.
   task automatic test_frame();
      int prevX, prevY, prevFc;
      logic prevVs;
      int vsX = -1, vsY = -1, vsLow = 0, vsWidth = -1;
      int fs1 = -1, fs2 = -1, fcPrev = -1, fcAt = -1, blankErr = 0;
      logic [3:0] expR;
      reset = 1'b1; step(); reset = 1'b0; step();
      prevX = int'(sx); prevY = int'(sy); prevVs = sVs; prevFc = int'(sFc);
      for (int c = 1; c <= 260; c++) begin
         step();
         if (prevVs && !sVs && vsX < 0) begin vsX = prevX; vsY = prevY; end
         if (!sVs && vsWidth < 0) vsLow++;
         else if (!prevVs && sVs && vsWidth < 0) vsWidth = vsLow;
         if (sFs) begin
            if (fs1 < 0) begin fs1 = c; fcPrev = prevFc; fcAt = int'(sFc); end
            else if (fs2 < 0) fs2 = c;
         end
         expR = (prevX < 8 && prevY < 4) ? 4'hF : 4'h0;
         if (sR !== expR) blankErr++;
         prevX = int'(sx); prevY = int'(sy); prevVs = sVs; prevFc = int'(sFc);
      end
      checks++; if (vsX != 0 || vsY != 5) begin failures++; $display("FAIL vsync_start got=(%0d,%0d) exp=(0,5)", vsX, vsY); end
      checks++; if (vsWidth != 30) begin failures++; $display("FAIL vsync_width got=%0d exp=30", vsWidth); end
      checks++; if (fs2 - fs1 != 120) begin failures++; $display("FAIL frame_period got=%0d exp=120", fs2 - fs1); end
      checks++; if (fcPrev != 0 || fcAt != 1) begin failures++; $display("FAIL frame_count_step got=%0d->%0d exp=0->1", fcPrev, fcAt); end
      checks++; if (blankErr != 0) begin failures++; $display("FAIL blanking_errors got=%0d exp=0", blankErr); end
   endtask

   // Reset while both syncs are low (x=11,y=5 on the small raster).
   task automatic test_midframe_reset();
      int found = 0, period = -1;
      for (int c = 0; c < 200; c++) begin
         if (sx == 10'd11 && sy == 10'd5) begin found = 1; break; end
         step();
      end
      checks++; if (found == 0) begin failures++; $display("FAIL midreset_reach got=none exp=x11y5"); end
      checks++; if (sHs !== 1'b0 || sVs !== 1'b0) begin failures++; $display("FAIL midreset_pre_sync got=%b%b exp=00", sHs, sVs); end
      reset = 1'b1; step();
      checks++; if (sx !== 10'd0 || sy !== 10'd0) begin failures++; $display("FAIL midreset_xy got=(%0d,%0d) exp=(0,0)", sx, sy); end
      checks++; if (sFs !== 1'b1) begin failures++; $display("FAIL midreset_frame_start got=%b exp=1", sFs); end
      checks++; if (sHs !== 1'b1 || sVs !== 1'b1) begin failures++; $display("FAIL midreset_sync got=%b%b exp=11", sHs, sVs); end
      checks++; if (sR !== 4'h0) begin failures++; $display("FAIL midreset_red got=%0h exp=0", sR); end
      reset = 1'b0; step();
      checks++; if (sx !== 10'd1) begin failures++; $display("FAIL midreset_next_x got=%0d exp=1", sx); end
      for (int c = 2; c < 300; c++) begin
         step();
         if (sFs) begin period = c; break; end
      end
      checks++; if (period != 120) begin failures++; $display("FAIL midreset_period got=%0d exp=120", period); end
   endtask

   // 256 small frames: frame_count wraps 255 -> 0 on the last pixel of frame 256.
   task automatic test_wrap();
      int prevX, prevY, prevFc, cnt, wrapAt = -1, wrapX = -1, wrapY = -1;
      reset = 1'b1; step(); reset = 1'b0; step();
      cnt = 1;
      prevX = int'(sx); prevY = int'(sy); prevFc = int'(sFc);
      while (cnt < 31000) begin
         step(); cnt++;
         if (prevFc == 255 && sFc == 8'd0) begin wrapAt = cnt; wrapX = prevX; wrapY = prevY; break; end
         prevX = int'(sx); prevY = int'(sy); prevFc = int'(sFc);
      end
      checks++; if (wrapAt != 30720) begin failures++; $display("FAIL wrap_cycle got=%0d exp=30720", wrapAt); end
      checks++; if (wrapX != 14 || wrapY != 7) begin failures++; $display("FAIL wrap_pixel got=(%0d,%0d) exp=(14,7)", wrapX, wrapY); end
   endtask

   initial begin
      reset = 1'b1; rIn = 4'hF; gIn = 4'hA; bIn = 4'h5;
      test_reset();
      test_line_timing();
      test_frame();
      test_midframe_reset();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameters SHALL be, as name, default, meaning: H_VISIBLE, 640, active pixels per line; H_FRONT, 16, front porch; H_SYNC, 96, hsync width; H_BACK, 48, back porch.
REQ-002 Further parameters: V_VISIBLE, 480, active lines; V_FRONT, 10, front porch; V_SYNC, 2, vsync width; V_BACK, 33, back porch.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Ports, as name, direction, width, meaning: clock25MHz, in, 1, pixel clock.
REQ-005 reset, in, 1, synchronous active-high reset.
REQ-006 red_in / green_in / blue_in, in, 4 each, pixel colour from the downstream pattern block for the current x,y.
REQ-007 x, out, 10, horizontal counter (0..H_TOTAL-1).
REQ-008 y, out, 10, vertical counter (0..V_TOTAL-1).
REQ-009 video_on, out, 1, high when x<H_VISIBLE and y<V_VISIBLE.
REQ-010 frame_start, out, 1, high for exactly the cycle where x==0 and y==0.
REQ-011 hsync / vsync, out, 1 each, active-low sync pulses aligned to the registered pixel outputs.
REQ-012 red / green / blue, out, 4 each, registered pixel outputs to the DAC pins.
REQ-013 frame_count, out, 8, completed-frame counter.

Function
REQ-014 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL SHALL equal V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
REQ-015 x SHALL increment by 1 every clock and wrap from H_TOTAL-1 to 0.
REQ-016 y SHALL increment only on the cycle when x wraps, and SHALL wrap from V_TOTAL-1 to 0 when x and y wrap together.
REQ-017 x, y, video_on and frame_start SHALL come directly from the counter registers, so they are valid in the same cycle.
REQ-018 red_in/green_in/blue_in SHALL be sampled in the same cycle as the x,y they correspond to, with a combinational downstream path.
REQ-019 red/green/blue SHALL register to the inputs when video_on is high, and to 0 otherwise; latency is 1 cycle from x,y.
REQ-020 hsync SHALL register to 0 when x is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] ([656,751]), and to 1 otherwise; latency is 1 cycle.
REQ-021 vsync SHALL register to 0 when y is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] ([490,491]), and to 1 otherwise; latency is 1 cycle.
REQ-022 frame_count SHALL increment modulo 256 on the cycle where x==H_TOTAL-1 and y==V_TOTAL-1.
REQ-023 Counter comparisons SHALL use at least 10-bit unsigned arithmetic, with no truncation at 799 or 524.
REQ-024 RGB input values SHALL have no effect during blanking; a nonzero red_in at x=640 SHALL give red=0 on the next cycle.

Reset
REQ-025 While reset is high at a clock edge: x=0, y=0, frame_count=0, red/green/blue=0, hsync=1, vsync=1.
REQ-026 On the first edge after reset deasserts, x SHALL become 1; during the reset-release cycle x=0, y=0, frame_start=1 and video_on=1.
REQ-027 A reset asserted mid-frame SHALL restart timing from x=0,y=0 with no partial sync pulse, because sync outputs are forced inactive.

Structure
REQ-028 The shared package vga_timing_pkg SHALL hold the default timing constants, H_TOTAL, V_TOTAL and the sync start/end derived values.
REQ-029 One sub-module, mod_counter (10-bit, enable, synchronous reset, wrap at a parameterised modulus, wrap flag output), SHALL be instantiated twice: horizontal with enable=1, and vertical with enable=horizontal wrap.
REQ-030 All outputs SHALL be driven from registers or counter state only; there SHALL be no combinational input-to-output path.

Verification
REQ-031 Reset test: hold reset for 5 cycles with red_in=F -> red=0, hsync=1, vsync=1, x=0, y=0, frame_count=0.
REQ-032 Line timing test: run 2 lines -> hsync falls 1 cycle after x=656, stays low exactly 96 cycles, and period is 800 cycles; y steps 0->1 when x wraps 799->0.
REQ-033 Frame timing test: run 1 full frame -> vsync is low for exactly 1600 cycles starting 1 cycle after x=0,y=490; frame_start period is 420000 cycles; frame_count goes 0->1.
REQ-034 Blanking test: drive rgb_in=F constantly -> outputs are F for cycles following x in 0..639 and y in 0..479, and 0 after x=640..799 and y=480..524.
REQ-035 Mid-frame reset test: assert reset at x=300,y=200 for 1 cycle -> next x=0,y=0, frame_start=1, and the frame restarts with correct timing.
REQ-036 Wrap test: run 256 frames -> frame_count wraps from 255 to 0 on the last pixel of frame 256.
